multicycle_processor: RTL and testbench
=======================================

Name: multicycle_processor

Overview:
- Parametrised multi-cycle MIPS-subset core and successor to the single-cycle datapath.
- A control FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified instruction/data memory port.
- The memory port uses a req/ready handshake, so it tolerates variable-latency memory.
- Adds correct branch/jump targets, illegal-opcode halt, a retired-instruction counter and the existing debug taps.

Parameters:
- WORD_SIZE, 32, datapath/register width; must be >= 32; instructions are always 32 bits (mem_rdata[31:0]).
- ADDR_WIDTH, 32, byte-address width of the memory port.
- RESET_PC, 0, PC value loaded on reset.
- CNT_WIDTH, 32, width of retire_count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-low.
- mem_req  out  1  memory request; held high until accepted.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_WIDTH  byte address, word aligned.
- mem_wdata  out  WORD_SIZE  store data.
- mem_rdata  in  WORD_SIZE  read data; valid in the cycle mem_req && mem_ready.
- mem_ready  in  1  completes the current request.
- halted  out  1  core stopped on an illegal opcode.
- retire_count  out  CNT_WIDTH  number of instructions completed.
- prog_count  out  WORD_SIZE  PC of the current instruction.
- instr_opcode  out  6  IR[31:26].
- reg1_addr, reg2_addr  out  5  IR[25:21], IR[20:16].
- reg1_data, reg2_data  out  WORD_SIZE  register-file read values.
- write_reg_addr  out  5  writeback destination.
- write_reg_data  out  WORD_SIZE  writeback value.

Behaviour:
- Reset (rst=0, async):
  - PC=RESET_PC; IR=0; all 32 registers=0; state=FETCH.
  - mem_req=0, mem_we=0; halted=0; retire_count=0.
  - Asserting reset mid-transaction drops mem_req immediately; memory must tolerate an abandoned request.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - On mem_ready: IR<=mem_rdata[31:0], PC<=PC+4, go to DECODE. Otherwise stay; all request outputs stay stable.
- DECODE:
  - A<=R[rs], B<=R[rt].
  - Supported opcodes go to EXEC; any other opcode goes to HALT.
- EXEC by class:
  - R-type (op 0x00), funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed): ALUOut<=A op B, go to WB. Any other funct goes to HALT.
  - addi (0x08): ALUOut<=A+sext(imm), go to WB.
  - lw (0x23) / sw (0x2B): ALUOut<=A+sext(imm), go to MEM.
  - beq (0x04): if A==B, PC<=PC+(sext(imm)<<2); PC already holds the incremented value. Retire, go to FETCH.
  - j (0x02): PC<={PC[W-1:28], IR[25:0], 2'b00}. Retire, go to FETCH.
- MEM:
  - mem_req=1, mem_addr=ALUOut[ADDR_WIDTH-1:0].
  - sw: mem_we=1, mem_wdata=B. On mem_ready: retire, go to FETCH.
  - lw: mem_we=0. On mem_ready: MDR<=mem_rdata, go to WB.
- WB:
  - Destination: R-type writes rd; addi/lw write rt.
  - Data: lw writes MDR; all others write ALUOut.
  - Writes to $0 are discarded; $0 always reads 0.
  - Retire, go to FETCH.
- Retire: retire_count increments by 1 and wraps modulo 2^CNT_WIDTH.
- Cycle counts with zero wait states (mem_ready=1 on the first req cycle): R/addi 4, lw 5, sw 4, beq/j 3. Each memory wait cycle adds 1.
- HALT:
  - halted=1, mem_req=0, no register or PC change; leave only by reset.
  - The illegal instruction does not retire.
- Arithmetic: two's complement, overflow ignored. sext extends imm[15] to WORD_SIZE.
- Debug taps: write_reg_addr/write_reg_data are valid in WB and show the last value otherwise. prog_count = PC - 4 after FETCH completes.

Decomposition:
- Shared package `mcp_pkg` holds:
  - opcode and funct localparams;
  - state encoding;
  - ALU operation codes, reusing the existing ALU_* defines.
- Sub-module `mcp_regfile` holds the 32xWORD_SIZE register file: two async read ports, one sync write port, $0 hardwired to 0, async active-low reset.
- ALU and FSM stay in the top module.

Test Plan:
- addi $1,$0,5 ; addi $2,$0,7 ; add $3,$1,$2 with zero-wait memory -> $3=12, write_reg_addr=3, retire_count=3 after 12 cycles.
- lw $4,8($0) with mem[8]=0xDEADBEEF and mem_ready delayed 3 cycles on the data access -> $4=0xDEADBEEF, lw takes 8 cycles, mem_addr=8 held stable while waiting.
- sw $3,0x10($0) after the first scenario -> one cycle with mem_req=1, mem_we=1, mem_addr=0x10, mem_wdata=12.
- beq $1,$1,-1 at PC 0x20 -> next fetch addr 0x20 (loop). beq with unequal operands -> next fetch 0x24. j 0x40 -> next fetch 0x100.
- Opcode 0x3F at PC 0x0C -> halted=1 after DECODE, mem_req stays 0, retire_count unchanged. Then rst pulse -> fetch at RESET_PC.
- rst asserted low mid-FETCH while waiting on mem_ready -> mem_req drops within the same cycle, retire_count=0, PC=RESET_PC. addi $0,$0,9 -> $0 still reads 0.

Source files
------------

// File: rtl/mcp_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core:
// opcodes, function codes, FSM states and ALU operations.
package mcp_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    // Opcodes the decoder accepts; anything else stops the core.
    function automatic logic op_supported(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/mcp_regfile.sv
// 32-entry register file: two asynchronous read ports,
// one synchronous write port, $0 hardwired to zero.
module mcp_regfile
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           ra1,
    input  logic [4:0]           ra2,
    output logic [WORD_SIZE-1:0] rd1,
    output logic [WORD_SIZE-1:0] rd2,
    input  logic                 we,
    input  logic [4:0]           wa,
    input  logic [WORD_SIZE-1:0] wd
);

    logic [WORD_SIZE-1:0] regs_q [32];
    logic [WORD_SIZE-1:0] regs_d [32];

    // Next register contents; $0 is forced back to zero every cycle.
    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end
        regs_d[0] = '0;
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1 = regs_q[ra1];
    assign rd2 = regs_q[ra2];

endmodule

// File: rtl/multicycle_processor.sv
// Multi-cycle MIPS-subset core: one ALU, one shared memory port
// with req/ready handshake, control FSM, illegal-opcode halt.
module multicycle_processor
    import mcp_pkg::*;
#(
    parameter int                   WORD_SIZE  = 32,
    parameter int                   ADDR_WIDTH = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
    parameter int                   CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    input  logic                  mem_ready,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  retire_count,
    output logic [WORD_SIZE-1:0]  prog_count,
    output logic [5:0]            instr_opcode,
    output logic [4:0]            reg1_addr,
    output logic [4:0]            reg2_addr,
    output logic [WORD_SIZE-1:0]  reg1_data,
    output logic [WORD_SIZE-1:0]  reg2_data,
    output logic [4:0]            write_reg_addr,
    output logic [WORD_SIZE-1:0]  write_reg_data
);

    localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(4);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t state_q, state_d;

    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] cur_pc_q, cur_pc_d;
    logic [31:0]          ir_q, ir_d;
    logic [WORD_SIZE-1:0] a_q, a_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [WORD_SIZE-1:0] alu_q, alu_d;
    logic [WORD_SIZE-1:0] mdr_q, mdr_d;
    logic [CNT_WIDTH-1:0] retire_q, retire_d;
    logic [4:0]           wr_addr_q, wr_addr_d;
    logic [WORD_SIZE-1:0] wr_data_q, wr_data_d;

    logic [5:0]           op;
    logic [5:0]           funct;
    logic [4:0]           rs, rt, rd;
    logic [15:0]          imm;
    logic [WORD_SIZE-1:0] imm_sext;
    logic                 is_rtype, is_mem, is_ctl;
    logic [4:0]           wb_dest;
    logic [WORD_SIZE-1:0] wb_data;
    logic [WORD_SIZE-1:0] rf_rd1, rf_rd2;

    alu_op_t              alu_op;
    logic                 funct_ok;
    logic [WORD_SIZE-1:0] alu_b, alu_res;

    logic                 rf_we;
    logic                 retire_en;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign imm_sext = {{(WORD_SIZE-16){imm[15]}}, imm};
    assign is_rtype = (op == OP_RTYPE);
    assign is_mem   = (op == OP_LW) || (op == OP_SW);
    assign is_ctl   = (op == OP_BEQ) || (op == OP_J);
    assign wb_dest  = is_rtype ? rd : rt;
    assign wb_data  = (op == OP_LW) ? mdr_q : alu_q;

    mcp_regfile #(
        .WORD_SIZE (WORD_SIZE)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (rf_we),
        .wa    (wb_dest),
        .wd    (wb_data)
    );

    // Map R-type function codes onto ALU operations; I-types add.
    always_comb begin
        alu_op   = ALU_ADD;
        funct_ok = 1'b1;
        if (is_rtype) begin
            unique case (1'b1)
                funct == FN_ADD: alu_op = ALU_ADD;
                funct == FN_SUB: alu_op = ALU_SUB;
                funct == FN_AND: alu_op = ALU_AND;
                funct == FN_OR:  alu_op = ALU_OR;
                funct == FN_SLT: alu_op = ALU_SLT;
                default:         funct_ok = 1'b0;
            endcase
        end
    end

    // Shared ALU: second operand is B for R-type, immediate otherwise.
    always_comb begin
        alu_b   = is_rtype ? b_q : imm_sext;
        alu_res = '0;
        unique case (alu_op)
            ALU_ADD: alu_res = a_q + alu_b;
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_SLT: alu_res = {{(WORD_SIZE-1){1'b0}},
                                ($signed(a_q) < $signed(alu_b))};
            default: alu_res = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = op_supported(op) ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_rtype:        state_d = funct_ok ? S_WB : S_HALT;
                    op == OP_ADDI:   state_d = S_WB;
                    is_mem:          state_d = S_MEM;
                    is_ctl:          state_d = S_FETCH;
                    default:         state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (op == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // FSM outputs; the request is gated by reset so it drops at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q[ADDR_WIDTH-1:0];
        halted    = 1'b0;
        rf_we     = 1'b0;
        retire_en = 1'b0;
        unique case (state_q)
            S_FETCH: mem_req = rst;
            S_EXEC:  retire_en = is_ctl;
            S_MEM: begin
                mem_req   = rst;
                mem_we    = rst && (op == OP_SW);
                mem_addr  = alu_q[ADDR_WIDTH-1:0];
                retire_en = mem_ready && (op == OP_SW);
            end
            S_WB: begin
                rf_we     = 1'b1;
                retire_en = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // Datapath register updates for each step of an instruction.
    always_comb begin
        pc_d      = pc_q;
        cur_pc_d  = cur_pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d     = mem_rdata[31:0];
                    pc_d     = pc_q + PC_STEP;
                    cur_pc_d = pc_q;
                end
            end
            S_DECODE: begin
                a_d = rf_rd1;
                b_d = rf_rd2;
            end
            S_EXEC: begin
                alu_d = alu_res;
                if ((op == OP_BEQ) && (a_q == b_q)) begin
                    pc_d = pc_q + (imm_sext << 2);
                end
                if (op == OP_J) begin
                    pc_d = {pc_q[WORD_SIZE-1:28], ir_q[25:0], 2'b00};
                end
            end
            S_MEM: begin
                if (mem_ready && (op == OP_LW)) mdr_d = mem_rdata;
            end
            S_WB: begin
                wr_addr_d = wb_dest;
                wr_data_d = wb_data;
            end
            default: ;
        endcase
        retire_d = retire_en ? retire_q + CNT_ONE : retire_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            cur_pc_q  <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            retire_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            pc_q      <= pc_d;
            cur_pc_q  <= cur_pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            retire_q  <= retire_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign mem_wdata      = b_q;
    assign retire_count   = retire_q;
    assign prog_count     = cur_pc_q;
    assign instr_opcode   = op;
    assign reg1_addr      = rs;
    assign reg2_addr      = rt;
    assign reg1_data      = rf_rd1;
    assign reg2_data      = rf_rd2;
    assign write_reg_addr = (state_q == S_WB) ? wb_dest : wr_addr_q;
    assign write_reg_data = (state_q == S_WB) ? wb_data : wr_data_q;

endmodule

// File: tb/tb_multicycle_processor.sv
// Self-checking bench for multicycle_processor: directed programs,
// an ALU vector table and a random program against a reference model.
module tb_multicycle_processor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        halted;
    logic [31:0] retire_count, prog_count;
    logic [5:0]  instr_opcode;
    logic [4:0]  reg1_addr, reg2_addr, write_reg_addr;
    logic [31:0] reg1_data, reg2_data, write_reg_data;

    multicycle_processor dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .halted         (halted),
        .retire_count   (retire_count),
        .prog_count     (prog_count),
        .instr_opcode   (instr_opcode),
        .reg1_addr      (reg1_addr),
        .reg2_addr      (reg2_addr),
        .reg1_data      (reg1_data),
        .reg2_data      (reg2_data),
        .write_reg_addr (write_reg_addr),
        .write_reg_data (write_reg_data)
    );

    always #5 clk = ~clk;

    // Memory model state; mem[] and wait_n are written by the test only.
    logic [31:0] mem [0:1023];
    int          wait_n = 0;
    int          cnt = 0;
    logic [31:0] st_addr [64];
    logic [31:0] st_data [64];
    int          st_n = 0;
    int          we_cyc = 0;
    logic [31:0] rd_log [256];
    int          rd_n = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // Variable-latency memory: ready after wait_n idle request cycles.
    always @(negedge clk) begin
        if (!rst) begin
            mem_ready = 1'b0;
            cnt = 0; st_n = 0; rd_n = 0; we_cyc = 0;
        end else if (mem_req) begin
            if (mem_we) we_cyc++;
            if (cnt >= wait_n) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[11:2]];
                cnt = 0;
                if (mem_we) begin
                    if (st_n < 64) begin
                        st_addr[st_n] = mem_addr;
                        st_data[st_n] = mem_wdata;
                        st_n++;
                    end
                end else if (rd_n < 256) begin
                    rd_log[rd_n] = mem_addr;
                    rd_n++;
                end
            end else begin
                mem_ready = 1'b0;
                cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            cnt = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    task automatic reset_core();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] idx);
        return {6'h02, idx};
    endfunction

    // Reference arithmetic for the R-type operations.
    function automatic logic [31:0] ref_alu(input logic [5:0] fn,
        input logic [31:0] a, input logic [31:0] b);
        case (fn)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h2A:   return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
            default: return 32'hx;
        endcase
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  fn;
        logic [31:0] exp;
    } vec_t;

    localparam int NR = 30;
    localparam logic [5:0] OPI = 6'h08;
    localparam logic [5:0] OPL = 6'h23;
    localparam logic [5:0] OPS = 6'h2B;
    localparam logic [5:0] OPB = 6'h04;

    initial begin
        vec_t        vecs [9];
        logic [31:0] exp_fetch [9];
        logic [31:0] prog [NR];
        logic        e_st [NR];
        logic [31:0] e_a [NR];
        logic [31:0] e_d [NR];
        logic [31:0] m_regs [8];
        logic [31:0] m_dmem [16];
        logic [5:0]  fns [5];
        logic [4:0]  rs, rt, rd;
        logic [15:0] im;
        logic [31:0] res;
        int          kind, k, st_idx, budget;

        vecs[0] = '{32'd5,        32'd7,        6'h20, 32'd12};
        vecs[1] = '{32'd5,        32'd7,        6'h22, 32'hFFFF_FFFE};
        vecs[2] = '{32'h0000F0F0, 32'h0000FF00, 6'h24, 32'h0000F000};
        vecs[3] = '{32'h0000F0F0, 32'h00000F0F, 6'h25, 32'h0000FFFF};
        vecs[4] = '{32'hFFFF_FFFF, 32'd1,       6'h2A, 32'd1};
        vecs[5] = '{32'd1,        32'hFFFF_FFFF, 6'h2A, 32'd0};
        vecs[6] = '{32'h7FFF_FFFF, 32'd1,       6'h20, 32'h8000_0000};
        vecs[7] = '{32'd0,        32'd1,        6'h22, 32'hFFFF_FFFF};
        vecs[8] = '{32'h8000_0000, 32'h7FFF_FFFF, 6'h2A, 32'd1};

        // Reset state.
        clear_mem();
        wait_n = 0;
        rst = 1'b0;
        cycles(2);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_retire", retire_count, 32'd0);

        // addi/addi/add then sw with zero-wait memory.
        mem[0] = enc_i(OPI, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(OPI, 5'd0, 5'd2, 16'd7);
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        mem[3] = enc_i(OPS, 5'd0, 5'd3, 16'h0010);
        reset_core();
        check("first_fetch_addr", mem_addr, 32'd0);
        cycles(11);
        check("add_retire_11", retire_count, 32'd2);
        cycles(1);
        check("add_retire_12", retire_count, 32'd3);
        check("add_wr_addr", {27'd0, write_reg_addr}, 32'd3);
        check("add_wr_data", write_reg_data, 32'd12);
        cycles(1);
        check("sw_prog_count", prog_count, 32'h0000000C);
        cycles(3);
        check("sw_retire", retire_count, 32'd4);
        check("sw_count", st_n, 32'd1);
        check("sw_we_cycles", we_cyc, 32'd1);
        check("sw_addr", st_addr[0], 32'h10);
        check("sw_data", st_data[0], 32'd12);

        // lw with three data wait cycles.
        clear_mem();
        mem[0] = enc_i(OPL, 5'd0, 5'd4, 16'd8);
        mem[2] = 32'hDEADBEEF;
        wait_n = 0;
        reset_core();
        cycles(1);
        wait_n = 3;
        cycles(2);
        for (int i = 0; i < 4; i++) begin
            check("lw_wait_req", {31'd0, mem_req}, 32'd1);
            check("lw_wait_addr", mem_addr, 32'd8);
            cycles(1);
        end
        check("lw_retire_7", retire_count, 32'd0);
        cycles(1);
        check("lw_retire_8", retire_count, 32'd1);
        check("lw_wr_addr", {27'd0, write_reg_addr}, 32'd4);
        check("lw_wr_data", write_reg_data, 32'hDEADBEEF);

        // Jumps and branches: fetch address sequence.
        clear_mem();
        wait_n = 0;
        mem[0]  = enc_i(OPI, 5'd0, 5'd1, 16'd5);
        mem[1]  = enc_i(OPI, 5'd0, 5'd2, 16'd7);
        mem[2]  = enc_j(26'h6);
        mem[6]  = enc_i(OPB, 5'd1, 5'd2, 16'd3);
        mem[7]  = enc_j(26'h40);
        mem[64] = enc_j(26'h8);
        mem[8]  = enc_i(OPB, 5'd1, 5'd1, 16'hFFFF);
        exp_fetch = '{32'h0, 32'h4, 32'h8, 32'h18, 32'h1C,
                      32'h100, 32'h20, 32'h20, 32'h20};
        reset_core();
        cycles(30);
        check("ctl_fetch_count_ok", {31'd0, rd_n >= 9}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("ctl_fetch_%0d", i), rd_log[i], exp_fetch[i]);
        end
        check("ctl_retire", retire_count, 32'd9);

        // Illegal opcode halts after DECODE without retiring.
        clear_mem();
        mem[0] = enc_i(OPI, 5'd0, 5'd1, 16'd1);
        mem[1] = enc_i(OPI, 5'd0, 5'd2, 16'd2);
        mem[2] = enc_i(OPI, 5'd0, 5'd3, 16'd3);
        mem[3] = 32'hFC00_0000;
        reset_core();
        cycles(13);
        check("halt_before", {31'd0, halted}, 32'd0);
        cycles(1);
        check("halt_after", {31'd0, halted}, 32'd1);
        check("halt_retire", retire_count, 32'd3);
        check("halt_pc", prog_count, 32'h0C);
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            check("halt_req", {31'd0, mem_req}, 32'd0);
        end
        check("halt_retire_hold", retire_count, 32'd3);
        reset_core();
        #1;
        check("halt_rst_halted", {31'd0, halted}, 32'd0);
        check("halt_rst_req", {31'd0, mem_req}, 32'd1);
        check("halt_rst_addr", mem_addr, 32'd0);

        // Unknown R-type function halts after EXEC.
        clear_mem();
        mem[0] = enc_r(5'd1, 5'd2, 5'd3, 6'h3F);
        reset_core();
        cycles(2);
        check("badfn_before", {31'd0, halted}, 32'd0);
        cycles(1);
        check("badfn_after", {31'd0, halted}, 32'd1);
        check("badfn_retire", retire_count, 32'd0);

        // Reset asserted while FETCH waits on memory.
        clear_mem();
        mem[0] = enc_i(OPI, 5'd0, 5'd1, 16'd1);
        mem[1] = enc_i(OPI, 5'd0, 5'd2, 16'd2);
        mem[2] = enc_i(OPI, 5'd0, 5'd3, 16'd3);
        reset_core();
        cycles(12);
        check("mid_retire_pre", retire_count, 32'd3);
        wait_n = 5;
        cycles(2);
        check("mid_req_pre", {31'd0, mem_req}, 32'd1);
        check("mid_addr_pre", mem_addr, 32'h0C);
        #2 rst = 1'b0;
        #1;
        check("mid_req_drop", {31'd0, mem_req}, 32'd0);
        check("mid_retire_clr", retire_count, 32'd0);
        check("mid_pc_reset", mem_addr, 32'd0);
        wait_n = 0;
        mem[0] = enc_i(OPI, 5'd0, 5'd0, 16'd9);
        mem[1] = enc_i(OPI, 5'd0, 5'd6, 16'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        cycles(8);
        check("r0_retire", retire_count, 32'd2);
        check("r0_wr_addr", {27'd0, write_reg_addr}, 32'd6);
        check("r0_reads_zero", write_reg_data, 32'd1);

        // ALU vector table: two loads then one R-type op.
        for (int v = 0; v < 9; v++) begin
            clear_mem();
            mem[0] = enc_i(OPL, 5'd0, 5'd1, 16'h0200);
            mem[1] = enc_i(OPL, 5'd0, 5'd2, 16'h0204);
            mem[2] = enc_r(5'd1, 5'd2, 5'd3, vecs[v].fn);
            mem[128] = vecs[v].a;
            mem[129] = vecs[v].b;
            reset_core();
            cycles(14);
            check($sformatf("vec_%0d_retire", v), retire_count, 32'd3);
            check($sformatf("vec_%0d_data", v), write_reg_data, vecs[v].exp);
        end

        // Random straight-line program against a reference model.
        clear_mem();
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 16; i++) begin
            m_dmem[i] = $urandom;
            mem[128 + i] = m_dmem[i];
        end
        for (int i = 0; i < NR; i++) begin
            kind = $urandom_range(0, 7);
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(1, 7));
            rd = 5'($urandom_range(1, 7));
            im = 16'($urandom);
            k = $urandom_range(0, 15);
            e_st[i] = 1'b0;
            if (kind == 0) begin
                res = m_regs[rs] + {{16{im[15]}}, im};
                prog[i] = enc_i(OPI, rs, rt, im);
                e_a[i] = {27'd0, rt};
                m_regs[rt] = res;
            end else if (kind <= 5) begin
                res = ref_alu(fns[kind-1], m_regs[rs], m_regs[rt]);
                prog[i] = enc_r(rs, rt, rd, fns[kind-1]);
                e_a[i] = {27'd0, rd};
                m_regs[rd] = res;
            end else if (kind == 6) begin
                res = m_dmem[k];
                prog[i] = enc_i(OPL, 5'd0, rt, 16'(32'h200 + 4 * k));
                e_a[i] = {27'd0, rt};
                m_regs[rt] = res;
            end else begin
                rt = 5'($urandom_range(0, 7));
                res = m_regs[rt];
                prog[i] = enc_i(OPS, 5'd0, rt, 16'(32'h300 + 4 * k));
                e_st[i] = 1'b1;
                e_a[i] = 32'h300 + 4 * k;
            end
            e_d[i] = res;
            mem[i] = prog[i];
        end
        wait_n = 0;
        reset_core();
        st_idx = 0;
        for (int i = 0; i < NR; i++) begin
            wait_n = $urandom_range(0, 2);
            budget = 0;
            while (retire_count != 32'(i + 1) && budget < 60) begin
                cycles(1);
                budget++;
            end
            check($sformatf("rnd_%0d_retire", i), retire_count, 32'(i + 1));
            if (retire_count != 32'(i + 1)) break;
            if (e_st[i]) begin
                check($sformatf("rnd_%0d_st_addr", i), st_addr[st_idx], e_a[i]);
                check($sformatf("rnd_%0d_st_data", i), st_data[st_idx], e_d[i]);
                st_idx++;
            end else begin
                check($sformatf("rnd_%0d_wr_addr", i),
                      {27'd0, write_reg_addr}, e_a[i]);
                check($sformatf("rnd_%0d_wr_data", i), write_reg_data, e_d[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
